// File: rtl/mmio_uart_tx_if.sv
// Word-addressed peripheral bus between the datapath and mmio_uart_tx.
// The master drives address/wdata/write; the slave returns combinational rdata.
interface mmio_uart_tx_if;
  logic [31:0] address;
  logic [63:0] wdata;
  logic        write;
  logic [63:0] rdata;

  modport master (
    output address,
    output wdata,
    output write,
    input  rdata
  );

  modport slave (
    input  address,
    input  wdata,
    input  write,
    output rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable divider.
// Define UART_TX_PARITY_EN to add an even-parity bit between DATA and STOP.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h100,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic         clock,
  input  logic         reset,
  mmio_uart_tx_if.slave bus,
  output logic         tx,
  output logic         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd1;
  localparam logic [31:0] BAUD_ADDR = BASE_ADDR + 32'd2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;
`endif

  state_e state_q, state_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   bit_div_q, bit_div_d;
  logic [15:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic sel_data, sel_stat, sel_baud;
  logic full, empty, bit_end;
  logic push_req, push, pop, ovf_set;
  logic [7:0] head;
  logic unused_wdata;

  assign sel_data = bus.address == BASE_ADDR;
  assign sel_stat = bus.address == STAT_ADDR;
  assign sel_baud = bus.address == BAUD_ADDR;

  assign full    = count_q == DEPTH_C;
  assign empty   = count_q == '0;
  assign bit_end = bit_cnt_q == (bit_div_q - 16'd1);
  assign head    = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign push_req = bus.write & sel_data;
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign busy = (state_q != S_IDLE) | ~empty;
  assign unused_wdata = ^bus.wdata[63:16];

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:
        if (bit_end && bit_idx_q == 3'd7)
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
`else
          state_d = S_STOP;
`endif
      S_STOP:
        if (bit_end) state_d = empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx  = 1'b1;
    pop = 1'b0;
    case (state_q)
      S_IDLE:   pop = ~empty;
      S_START:  tx  = 1'b0;
      S_DATA:   tx  = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx  = par_q;
`endif
      S_STOP:   pop = bit_end & ~empty;
      default:  tx  = 1'b1;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) mem_d[wr_ptr_q] = bus.wdata[7:0];

    ovf_d = ovf_q;
    if (bus.write && sel_stat && bus.wdata[3])
      ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    div_d = div_q;
    if (bus.write && sel_baud)
      div_d = (bus.wdata[15:0] == 16'd0) ?
              16'd1 : bus.wdata[15:0];
  end

  // Frame timing is frozen at pop; BAUD writes only reach the next frame.
  always_comb begin
    bit_div_d = pop ? div_q : bit_div_q;
    bit_cnt_d = bit_cnt_q + 16'd1;
    if (state_q == S_IDLE || bit_end)
      bit_cnt_d = 16'd0;
    bit_idx_d = 3'd0;
    if (state_q == S_DATA)
      bit_idx_d = bit_end ? bit_idx_q + 3'd1 : bit_idx_q;
    shift_d = shift_q;
    if (pop)
      shift_d = head;
    else if (state_q == S_DATA && bit_end)
      shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^head : par_q;
`endif
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DEFAULT_DIV;
      bit_div_q <= DEFAULT_DIV;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      bit_div_q <= bit_div_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    bus.rdata = 64'd0;
    unique case (1'b1)
      sel_stat:
        bus.rdata = {48'd0, 8'(count_q), 4'd0,
                     ovf_q, empty, full, busy};
      sel_baud: bus.rdata = {48'd0, div_q};
      default:  bus.rdata = 64'd0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register table, corner sequences,
// and random byte bursts checked against a bit-stream model of the frames.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_DATA = 32'h100;
  localparam logic [31:0] A_STAT = 32'h101;
  localparam logic [31:0] A_BAUD = 32'h102;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx, busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h100),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic txlog[$];
  logic busylog[$];
  logic exp_q[$];

  typedef struct {
    logic        do_wr;
    logic [31:0] wa;
    logic [63:0] wd;
    logic [31:0] ra;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: log outputs left by the previous edge, then drive the next.
  task automatic step(input logic w, input logic [31:0] a,
                      input logic [63:0] d);
    @(negedge clock);
    txlog.push_back(tx);
    busylog.push_back(busy);
    bus.write   = w;
    bus.address = a;
    bus.wdata   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, A_STAT, 64'd0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [63:0] v);
    bus.write   = 1'b0;
    bus.address = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  // Expected line level per clock for one frame of byte b at divisor div.
  task automatic add_frame(input logic [7:0] b, input int div);
    repeat (div) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      repeat (div) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (div) exp_q.push_back(^b);
`endif
    repeat (div) exp_q.push_back(1'b1);
  endtask

  task automatic start_log();
    txlog.delete();
    busylog.delete();
  endtask

  // txlog[0] is the edge of the first push; the line starts one edge later.
  task automatic check_stream(input string nm);
    int len;
    int need;
    len  = exp_q.size();
    need = len + 2 - txlog.size();
    if (need > 0) idle(need);
    for (int j = 0; j < len; j++)
      chk($sformatf("%s_bit%0d", nm, j), 64'(txlog[j+1]), 64'(exp_q[j]));
    chk({nm, "_busy_last"}, 64'(busylog[len]), 64'd1);
    chk({nm, "_tx_idle"}, 64'(txlog[len+1]), 64'd1);
    chk({nm, "_busy_idle"}, 64'(busylog[len+1]), 64'd0);
  endtask

  initial begin
    logic [63:0] v;
    logic [7:0]  bytes[$];
    int div;
    int n;

    bus.write   = 1'b0;
    bus.address = 32'd0;
    bus.wdata   = 64'd0;

    tbl[0]  = '{1'b0, 32'h0,   64'h0,    A_STAT, 64'h4,     "rst_status"};
    tbl[1]  = '{1'b0, 32'h0,   64'h0,    A_BAUD, 64'd434,   "rst_baud"};
    tbl[2]  = '{1'b0, 32'h0,   64'h0,    A_DATA, 64'h0,     "rd_txdata"};
    tbl[3]  = '{1'b1, A_BAUD,  64'h0,    A_BAUD, 64'h1,     "baud_zero"};
    tbl[4]  = '{1'b1, A_BAUD,  64'hFFFF_FFFF_0001_0005,
                A_BAUD, 64'h5, "baud_upper"};
    tbl[5]  = '{1'b1, 32'h103, 64'h9,    A_BAUD, 64'h5,     "wr_base3"};
    tbl[6]  = '{1'b0, 32'h0,   64'h0,    32'h103, 64'h0,    "rd_base3"};
    tbl[7]  = '{1'b1, 32'h0FF, 64'h77,   A_STAT, 64'h4,     "wr_0ff"};
    tbl[8]  = '{1'b0, 32'h0,   64'h0,    32'h0FF, 64'h0,    "rd_0ff"};
    tbl[9]  = '{1'b1, A_STAT,  64'hFF,   A_STAT, 64'h4,     "wr_status"};
    tbl[10] = '{1'b1, 32'h000, 64'h12,   A_STAT, 64'h4,     "wr_000"};
    tbl[11] = '{1'b0, 32'h0,   64'h0,    32'h302, 64'h0,    "rd_302"};
    tbl[12] = '{1'b1, A_BAUD,  64'hFFFF, A_BAUD, 64'hFFFF,  "baud_max"};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].do_wr) step(1'b1, tbl[i].wa, tbl[i].wd);
      step(1'b0, tbl[i].ra, 64'd0);
      rd(tbl[i].ra, v);
      chk(tbl[i].nm, v, tbl[i].exp);
    end

    // Single frame of A5 at div 4.
    do_reset();
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    step(1'b1, A_BAUD, 64'd4);
    exp_q.delete();
    add_frame(8'hA5, 4);
    step(1'b1, A_DATA, 64'hA5);
    start_log();
    check_stream("a5");

    // Nine back-to-back pushes, then overflow and clear.
    step(1'b1, A_BAUD, 64'd2);
    exp_q.delete();
    for (int i = 0; i < 9; i++) add_frame(8'(i * 17 + 1), 2);
    step(1'b1, A_DATA, 64'd1);
    start_log();
    for (int i = 1; i < 9; i++) step(1'b1, A_DATA, 64'(i * 17 + 1));
    step(1'b0, A_STAT, 64'd0);
    rd(A_STAT, v);
    chk("nine_full", v, 64'h803);
    step(1'b1, A_DATA, 64'hEE);
    step(1'b0, A_STAT, 64'd0);
    rd(A_STAT, v);
    chk("overflow_set", v, 64'h80B);
    step(1'b1, A_STAT, 64'h8);
    step(1'b0, A_STAT, 64'd0);
    rd(A_STAT, v);
    chk("overflow_clr", v, 64'h803);
    check_stream("nine");

    // Push while full on the STOP->START pop edge.
    exp_q.delete();
    for (int i = 0; i < 10; i++) add_frame(8'(8'hC0 + i), 2);
    step(1'b1, A_DATA, 64'hC0);
    start_log();
    for (int i = 1; i < 9; i++) step(1'b1, A_DATA, 64'(8'hC0 + i));
    idle(NBITS * 2 - 8);
    step(1'b1, A_DATA, 64'hC9);
    step(1'b0, A_STAT, 64'd0);
    rd(A_STAT, v);
    chk("push_pop_full", v, 64'h803);
    check_stream("popedge");

    // BAUD change mid-frame only reaches the next frame.
    step(1'b1, A_BAUD, 64'd3);
    exp_q.delete();
    add_frame(8'h81, 3);
    add_frame(8'h42, 5);
    step(1'b1, A_DATA, 64'h81);
    start_log();
    idle(5);
    step(1'b1, A_BAUD, 64'd5);
    step(1'b1, A_DATA, 64'h42);
    step(1'b0, A_BAUD, 64'd0);
    rd(A_BAUD, v);
    chk("baud_mid", v, 64'd5);
    check_stream("midbaud");

    // Parity-relevant byte at div 4.
    step(1'b1, A_BAUD, 64'd4);
    exp_q.delete();
    add_frame(8'h07, 4);
    step(1'b1, A_DATA, 64'h07);
    start_log();
    check_stream("b07");

    // Reset in the middle of DATA with a byte still queued.
    step(1'b1, A_DATA, 64'h3C);
    step(1'b1, A_DATA, 64'h5A);
    idle(12);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    step(1'b0, A_STAT, 64'd0);
    reset = 1'b1;
    chk("mid_rst_tx", 64'(txlog[$]), 64'd1);
    chk("mid_rst_busy", 64'(busylog[$]), 64'd0);
    rd(A_STAT, v);
    chk("mid_rst_status", v, 64'h4);
    rd(A_BAUD, v);
    chk("mid_rst_baud", v, 64'd434);
    start_log();
    idle(60);
    for (int i = 0; i < 60; i++)
      if (txlog[i] !== 1'b1 || busylog[i] !== 1'b0) begin
        chk("post_rst_quiet", {txlog[i], busylog[i]}, 64'h2);
        break;
      end

    // Random bursts against the frame model.
    for (int it = 0; it < 8; it++) begin
      div = $urandom_range(1, 5);
      n   = $urandom_range(1, 9);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      step(1'b1, A_BAUD, 64'(div));
      exp_q.delete();
      foreach (bytes[i]) add_frame(bytes[i], div);
      step(1'b1, A_DATA, 64'(bytes[0]));
      start_log();
      for (int i = 1; i < n; i++) step(1'b1, A_DATA, 64'(bytes[i]));
      check_stream($sformatf("rnd%0d", it));
      step(1'b0, A_STAT, 64'd0);
      rd(A_STAT, v);
      chk($sformatf("rnd%0d_status", it), v, 64'h4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
